// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: UART RX byte hand-off plus FWFT valid/ready consumer port for uart_rx_fifo
//   rx_data/rx_rc/rx_read_complete : byte, ready flag and same-cycle ack toward the UART RX controller
//   out_data/out_valid/out_ready   : head-of-FIFO byte, not-empty flag, consumer accept
//   master = UART RX + consumer side, slave = the FIFO
interface uart_rx_fifo_if;
  logic [7:0] rx_data;
  logic       rx_rc;
  logic       rx_read_complete;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  modport master(output rx_data, rx_rc, out_ready, input rx_read_complete, out_data, out_valid);
  modport slave(input rx_data, rx_rc, out_ready, output rx_read_complete, out_data, out_valid);
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: DEPTH-entry first-word-fall-through byte buffer behind a UART RX controller
//   clk, reset_n (async, active-low)   : clock and reset
//   bus (uart_rx_fifo_if.slave)        : UART RX hand-off and consumer valid/ready port
//   level, full                        : stored byte count (0..DEPTH) and level == DEPTH
//   overflow, clear_overflow           : sticky drop flag and its synchronous clear
//   `define UART_RX_FIFO_DROP_EN       : ack and discard bytes while full instead of stalling the UART
module uart_rx_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  uart_rx_fifo_if.slave     bus,
  output logic [ADDR_W:0]   level,
  output logic              full,
  output logic              overflow,
  input  logic              clear_overflow
);
  logic [7:0]      mem [DEPTH];
  logic [ADDR_W:0] wr_ptr, rd_ptr;
  logic            pop, push, drop;
  assign full          = wr_ptr == {~rd_ptr[ADDR_W], rd_ptr[ADDR_W-1:0]};
  assign level         = wr_ptr - rd_ptr;
  assign bus.out_valid = wr_ptr != rd_ptr;
  assign bus.out_data  = mem[rd_ptr[ADDR_W-1:0]];
  assign pop           = bus.out_valid & bus.out_ready;
  // reset_n gates the ack so a byte offered during reset is never acknowledged
  assign push          = reset_n & bus.rx_rc & (~full | pop);
`ifdef UART_RX_FIFO_DROP_EN
  assign drop = reset_n & bus.rx_rc & full & ~pop;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) overflow <= 1'b0;
    else overflow <= clear_overflow ? 1'b0 : (drop ? 1'b1 : overflow);
`else
  logic unused_clear;
  assign drop         = 1'b0;
  assign overflow     = 1'b0;
  assign unused_clear = clear_overflow;
`endif
  assign bus.rx_read_complete = push | drop;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (ADDR_W+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (ADDR_W+1)'(1);
    end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr[ADDR_W-1:0]] <= bus.rx_data;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: queue-model checker plus directed scenarios for uart_rx_fifo
module tb_uart_rx_fifo;
  logic       clk = 0;
  logic       reset_n = 0;
  logic       clear_overflow = 0;
  logic [4:0] level;
  logic       full, overflow;
  int         passed = 0, total = 0, max_level = 0;
  logic [7:0] q[$];
  logic [7:0] pop_log[$];
  bit         ovf_m = 0;
  uart_rx_fifo_if bus();
  uart_rx_fifo #(.DEPTH(16), .ADDR_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .level(level), .full(full),
    .overflow(overflow), .clear_overflow(clear_overflow));
  always #5 clk = ~clk;
`ifdef UART_RX_FIFO_DROP_EN
  localparam bit DROP = 1;
`else
  localparam bit DROP = 0;
`endif
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask
  // Model: queue of stored bytes; outputs derived from its size and the upstream/consumer rules.
  always @(negedge clk) begin
    if (!reset_n) begin
      q.delete();
      ovf_m = 0;
      chk("rst_ack", bus.rx_read_complete, 0);
      chk("rst_valid", bus.out_valid, 0);
      chk("rst_level", level, 0);
      chk("rst_full", full, 0);
      chk("rst_ovf", overflow, 0);
    end else begin
      bit p, w, d, f;
      f = q.size() == 16;
      p = q.size() > 0 && bus.out_ready;
      w = bus.rx_rc && (!f || p);
      d = DROP && bus.rx_rc && f && !p;
      chk("valid", bus.out_valid, q.size() > 0);
      chk("level", level, q.size());
      chk("full", full, f);
      chk("ack", bus.rx_read_complete, w || d);
      chk("ovf", overflow, ovf_m);
      if (q.size() > 0) chk("data", bus.out_data, q[0]);
      if (q.size() > max_level) max_level = q.size();
      if (p) begin
        pop_log.push_back(bus.out_data);
        void'(q.pop_front());
      end
      if (w) q.push_back(bus.rx_data);
      if (DROP) ovf_m = clear_overflow ? 0 : (d ? 1 : ovf_m);
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] b);
    bit ok = 0;
    bus.rx_rc = 1;
    bus.rx_data = b;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = bus.rx_read_complete;
      tick();
    end
    bus.rx_rc = 0;
    if (!ok) chk("send_timeout", 0, 1);
  endtask
  task automatic drain();
    bus.out_ready = 1;
    for (int i = 0; i < 100 && level != 0; i++) tick();
    bus.out_ready = 0;
    chk("drained", level, 0);
  endtask
  task automatic do_reset();
    reset_n = 0;
    tick();
    tick();
    reset_n = 1;
    tick();
    pop_log.delete();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    bus.rx_rc = 0;
    bus.rx_data = 0;
    bus.out_ready = 0;
    do_reset();
    // 1: single byte, visible after the push edge
    bus.rx_rc = 1;
    bus.rx_data = 8'hA5;
    @(negedge clk);
    chk("t1_ack", bus.rx_read_complete, 1);
    tick();
    bus.rx_rc = 0;
    @(negedge clk);
    chk("t1_valid", bus.out_valid, 1);
    chk("t1_data", bus.out_data, 8'hA5);
    chk("t1_level", level, 1);
    tick();
    drain();
`ifndef UART_RX_FIFO_DROP_EN
    // 2: fill, back-pressure, then push accepted alongside a pop while full
    for (int i = 0; i < 16; i++) send(8'(i));
    bus.rx_rc = 1;
    bus.rx_data = 8'h10;
    @(negedge clk);
    chk("t2_full", full, 1);
    chk("t2_level", level, 16);
    chk("t2_noack", bus.rx_read_complete, 0);
    tick();
    bus.out_ready = 1;
    @(negedge clk);
    chk("t2_ack", bus.rx_read_complete, 1);
    tick();
    bus.rx_rc = 0;
    bus.out_ready = 0;
    @(negedge clk);
    chk("t2_level2", level, 16);
    chk("t2_head", bus.out_data, 8'h01);
    tick();
    drain();
`endif
    // 3: stream 40 bytes through a half-rate consumer, wrapping the pointers
    do_reset();
    max_level = 0;
    fork
      for (int i = 0; i < 40; i++) begin
        send(8'(8'h30 + i));
        if (DROP) tick();
      end
      for (int c = 0; c < 600 && pop_log.size() < 40; c++) begin
        bus.out_ready = ~bus.out_ready;
        tick();
      end
    join
    bus.out_ready = 0;
    chk("t3_count", pop_log.size(), 40);
    for (int i = 0; i < 40 && i < pop_log.size(); i++) chk("t3_order", pop_log[i], 8'h30 + i);
    chk("t3_maxlvl_ok", max_level <= 16, 1);
    // 4: reset mid-cycle with a byte on offer
    do_reset();
    for (int i = 0; i < 5; i++) send(8'(8'h60 + i));
    bus.rx_rc = 1;
    bus.rx_data = 8'h99;
    #2;
    reset_n = 0;
    #1;
    chk("t4_ack", bus.rx_read_complete, 0);
    chk("t4_valid", bus.out_valid, 0);
    chk("t4_level", level, 0);
    tick();
    bus.rx_rc = 0;
    tick();
    reset_n = 1;
    pop_log.delete();
    tick();
    send(8'h77);
    drain();
    chk("t4_count", pop_log.size(), 1);
    if (pop_log.size() > 0) chk("t4_first", pop_log[0], 8'h77);
`ifdef UART_RX_FIFO_DROP_EN
    // 5: drop while full sets sticky overflow; clear wins
    do_reset();
    for (int i = 0; i < 16; i++) send(8'(8'h80 + i));
    bus.rx_rc = 1;
    bus.rx_data = 8'hEE;
    @(negedge clk);
    chk("t5_ack", bus.rx_read_complete, 1);
    tick();
    bus.rx_rc = 0;
    @(negedge clk);
    chk("t5_ovf", overflow, 1);
    chk("t5_head", bus.out_data, 8'h80);
    chk("t5_level", level, 16);
    tick();
    clear_overflow = 1;
    tick();
    clear_overflow = 0;
    @(negedge clk);
    chk("t5_clr", overflow, 0);
    tick();
    drain();
    chk("t5_count", pop_log.size(), 16);
    for (int i = 0; i < pop_log.size(); i++) chk("t5_noEE", pop_log[i] == 8'hEE, 0);
`else
    clear_overflow = 1;
    tick();
    clear_overflow = 0;
    @(negedge clk);
    chk("t5_tied", overflow, 0);
    tick();
`endif
    // 6: always-ready consumer, single byte popped exactly once
    do_reset();
    bus.out_ready = 1;
    send(8'h42);
    for (int i = 0; i < 5; i++) tick();
    bus.out_ready = 0;
    chk("t6_count", pop_log.size(), 1);
    if (pop_log.size() > 0) chk("t6_byte", pop_log[0], 8'h42);
    chk("t6_level", level, 0);
    tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
